// File: rtl/ibex_rf_wb_arbiter.sv
// Write-back arbiter in front of the single write port of the FPGA register file.
// Merges EX results (back-pressurable) and LSU load data (never stalled) onto
// one port, using a one-entry pending buffer to absorb collisions. After reset
// it sweeps every register except x0 to WordZeroVal, because the FPGA register
// file itself has no reset.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   ex_valid_i/ex_ready_o              EX write handshake
//   ex_waddr_i, ex_wdata_i             EX destination and data
//   lsu_we_i, lsu_waddr_i, lsu_wdata_i load write; must be taken this cycle
//   rf_we_o, rf_waddr_o, rf_wdata_o    register-file write port
//   pend_valid_o/waddr_o/wdata_o       pending buffer contents, for ID bypass
//   init_busy_o                        init sweep in progress
//   err_o                              load write arrived during the sweep
module ibex_rf_wb_arbiter #(
  parameter bit                    RV32E        = 1'b0,
  parameter int unsigned           DataWidth    = 32,
  parameter logic [DataWidth-1:0]  WordZeroVal  = '0,
  parameter bit                    ClearOnReset = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_we_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 pend_valid_o,
  output logic [4:0]           pend_waddr_o,
  output logic [DataWidth-1:0] pend_wdata_o,
  output logic                 init_busy_o,
  output logic                 err_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam logic [4:0]  LastAddr = 5'(NumWords - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [4:0]           pend_waddr_q, pend_waddr_d;
  logic [DataWidth-1:0] pend_wdata_q, pend_wdata_d;

  logic lsu_act;  // load write that really needs the port (x0 is free)
  logic ex_acc;   // EX accepted and needs the port (x0 is dropped)

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ClearOnReset ? INIT : RUN;
      cnt_q        <= 5'd1;
      pend_valid_q <= 1'b0;
      pend_waddr_q <= '0;
      pend_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_waddr_q <= pend_waddr_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_waddr_d = pend_waddr_q;
    pend_wdata_d = pend_wdata_q;
    rf_we_o      = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    ex_ready_o   = 1'b0;
    err_o        = 1'b0;
    init_busy_o  = 1'b0;
    lsu_act      = lsu_we_i && (lsu_waddr_i != 5'd0);
    ex_acc       = 1'b0;

    if (rst_i) begin
      // Registers are being reloaded; keep the port and handshakes quiet.
      init_busy_o = ClearOnReset;
    end else begin
      unique case (state_q)
        INIT: begin
          rf_we_o     = 1'b1;
          rf_waddr_o  = cnt_q;
          rf_wdata_o  = WordZeroVal;
          init_busy_o = 1'b1;
          err_o       = lsu_we_i;  // the load is dropped
          cnt_d       = cnt_q + 5'd1;
          if (cnt_q == LastAddr) state_d = RUN;
        end
        RUN: begin
          // Only a full buffer that cannot drain (port taken by a load) stalls EX.
          ex_ready_o = !(pend_valid_q && lsu_act);
          ex_acc     = ex_valid_i && ex_ready_o && (ex_waddr_i != 5'd0);
          if (lsu_act) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
            // ex_acc implies the buffer is empty here.
            if (ex_acc) begin
              pend_valid_d = 1'b1;
              pend_waddr_d = ex_waddr_i;
              pend_wdata_d = ex_wdata_i;
            end
          end else if (pend_valid_q) begin
            // Drain first so the older EX result keeps program order.
            rf_we_o      = 1'b1;
            rf_waddr_o   = pend_waddr_q;
            rf_wdata_o   = pend_wdata_q;
            pend_valid_d = ex_acc;
            if (ex_acc) begin
              pend_waddr_d = ex_waddr_i;
              pend_wdata_d = ex_wdata_i;
            end
          end else if (ex_acc) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign pend_valid_o = pend_valid_q && !rst_i;
  assign pend_waddr_o = pend_waddr_q;
  assign pend_wdata_o = pend_wdata_q;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
module tb_ibex_rf_wb_arbiter;

  localparam logic [31:0] WZV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_waddr = '0;
  logic [31:0] ex_wdata = '0;
  logic        lsu_we = 1'b0;
  logic [4:0]  lsu_waddr = '0;
  logic [31:0] lsu_wdata = '0;

  logic        ex_ready, rf_we, pend_valid, init_busy, err;
  logic [4:0]  rf_waddr, pend_waddr;
  logic [31:0] rf_wdata, pend_wdata;

  logic        ex_ready16, rf_we16, pend_valid16, init_busy16, err16;
  logic [4:0]  rf_waddr16, pend_waddr16;
  logic [31:0] rf_wdata16, pend_wdata16;

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(WZV), .ClearOnReset(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .pend_valid_o(pend_valid), .pend_waddr_o(pend_waddr), .pend_wdata_o(pend_wdata),
    .init_busy_o(init_busy), .err_o(err)
  );

  ibex_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(WZV), .ClearOnReset(1'b1)) dut16 (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready16), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we16), .rf_waddr_o(rf_waddr16), .rf_wdata_o(rf_wdata16),
    .pend_valid_o(pend_valid16), .pend_waddr_o(pend_waddr16), .pend_wdata_o(pend_wdata16),
    .init_busy_o(init_busy16), .err_o(err16)
  );

  typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [31:0] exv, exa, exd, lw, la, ld;  // inputs
    logic [31:0] rdy, pv, pa, pd, we, wa, wd; // expected outputs
  } vec_t;
  vec_t vecs[21];

  logic [31:0] rf_obs[32];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called once per cycle at the falling edge: pop the expected write, if any.
  task automatic check_port();
    wr_t e;
    logic present;
    present = (exp_q.size() > 0);
    chk("rf_we", 32'(rf_we), 32'(present));
    if (present) begin
      e = exp_q.pop_front();
      if (rf_we) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
        chk("rf_wdata", rf_wdata, e.d);
      end
    end
    if (rf_we) rf_obs[rf_waddr] = rf_wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 1'b0; ex_waddr = '0; ex_wdata = '0;
    lsu_we = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
  endtask

  // Two reset cycles with busy inputs to prove every output is gated.
  task automatic do_reset();
    rst = 1'b1;
    ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h1;
    lsu_we = 1'b1; lsu_waddr = 5'd1; lsu_wdata = 32'h1;
    for (int c = 0; c < 2; c++) begin
      #4;
      chk("rst_ex_ready", 32'(ex_ready), 0);
      chk("rst_pend_valid", 32'(pend_valid), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_init_busy", 32'(init_busy), 1);
      chk("rst_rf_we16", 32'(rf_we16), 0);
      check_port();
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  // Starts in the first cycle after reset release; ends in cycle 33.
  task automatic sweep(input int err_cyc);
    for (int i = 1; i <= 32; i++) begin
      lsu_we    = (i == err_cyc);
      lsu_waddr = (i == err_cyc) ? 5'd10 : 5'd0;
      lsu_wdata = 32'h55;
      if (i <= 31) exp_q.push_back('{5'(i), WZV});
      #4;
      chk("sweep_busy", 32'(init_busy), 32'(i <= 31));
      chk("sweep_ex_ready", 32'(ex_ready), 32'(i == 32));
      chk("sweep_err", 32'(err), 32'(i == err_cyc));
      check_port();
      if (i <= 16) begin
        chk("sweep16_we", 32'(rf_we16), 32'(i <= 15));
        chk("sweep16_busy", 32'(init_busy16), 32'(i <= 15));
      end
      if (i <= 15) begin
        chk("sweep16_waddr", 32'(rf_waddr16), 32'(i));
        chk("sweep16_wdata", rf_wdata16, WZV);
      end
      if (i == 16) chk("sweep16_ex_ready", 32'(ex_ready16), 1);
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    //          exv exa  exd           lw la  ld           rdy pv pa  pd           we wa  wd
    vecs[0]  = '{0, 0,  0,            0, 0,  0,            1, 0, 0,  0,            0, 0,  0};
    vecs[1]  = '{1, 5,  32'h1111_2222, 0, 0,  0,            1, 0, 0,  0,            1, 5,  32'h1111_2222};
    vecs[2]  = '{1, 5,  32'hAAAA_0000, 1, 7,  32'h1234,     1, 0, 0,  0,            1, 7,  32'h1234};
    vecs[3]  = '{0, 0,  0,            0, 0,  0,            1, 1, 5,  32'hAAAA_0000, 1, 5,  32'hAAAA_0000};
    vecs[4]  = '{0, 0,  0,            0, 0,  0,            1, 0, 0,  0,            0, 0,  0};
    vecs[5]  = '{1, 3,  32'h33,       1, 2,  32'h22,       1, 0, 0,  0,            1, 2,  32'h22};
    vecs[6]  = '{1, 6,  32'h66,       1, 4,  32'h44,       0, 1, 3,  32'h33,       1, 4,  32'h44};
    vecs[7]  = '{1, 6,  32'h66,       0, 0,  0,            1, 1, 3,  32'h33,       1, 3,  32'h33};
    vecs[8]  = '{0, 0,  0,            0, 0,  0,            1, 1, 6,  32'h66,       1, 6,  32'h66};
    vecs[9]  = '{0, 0,  0,            0, 0,  0,            1, 0, 0,  0,            0, 0,  0};
    vecs[10] = '{1, 9,  1,            1, 9,  2,            1, 0, 0,  0,            1, 9,  2};
    vecs[11] = '{0, 0,  0,            0, 0,  0,            1, 1, 9,  1,            1, 9,  1};
    vecs[12] = '{1, 0,  32'hFF,       0, 0,  0,            1, 0, 0,  0,            0, 0,  0};
    vecs[13] = '{1, 0,  32'hFF,       1, 8,  32'h88,       1, 0, 0,  0,            1, 8,  32'h88};
    vecs[14] = '{0, 0,  0,            0, 0,  0,            1, 0, 0,  0,            0, 0,  0};
    vecs[15] = '{1, 10, 32'hA,        1, 11, 32'hB,        1, 0, 0,  0,            1, 11, 32'hB};
    vecs[16] = '{1, 12, 32'hC,        1, 0,  32'hEE,       1, 1, 10, 32'hA,        1, 10, 32'hA};
    vecs[17] = '{1, 13, 32'hD,        1, 14, 32'hE,        0, 1, 12, 32'hC,        1, 14, 32'hE};
    vecs[18] = '{1, 13, 32'hD,        0, 0,  0,            1, 1, 12, 32'hC,        1, 12, 32'hC};
    vecs[19] = '{0, 0,  0,            0, 0,  0,            1, 1, 13, 32'hD,        1, 13, 32'hD};
    vecs[20] = '{0, 0,  0,            0, 0,  0,            1, 0, 0,  0,            0, 0,  0};

    for (int r = 0; r < 32; r++) rf_obs[r] = '0;

    next_cycle();
    do_reset();
    sweep(10);

    foreach (vecs[k]) begin
      ex_valid  = vecs[k].exv[0];
      ex_waddr  = vecs[k].exa[4:0];
      ex_wdata  = vecs[k].exd;
      lsu_we    = vecs[k].lw[0];
      lsu_waddr = vecs[k].la[4:0];
      lsu_wdata = vecs[k].ld;
      if (vecs[k].we[0]) exp_q.push_back('{vecs[k].wa[4:0], vecs[k].wd});
      #4;
      chk($sformatf("v%0d_ex_ready", k), 32'(ex_ready), vecs[k].rdy);
      chk($sformatf("v%0d_pend_valid", k), 32'(pend_valid), vecs[k].pv);
      if (vecs[k].pv[0]) begin
        chk($sformatf("v%0d_pend_waddr", k), 32'(pend_waddr), vecs[k].pa);
        chk($sformatf("v%0d_pend_wdata", k), pend_wdata, vecs[k].pd);
      end
      chk($sformatf("v%0d_err", k), 32'(err), 0);
      check_port();
      next_cycle();
    end
    clear_inputs();
    chk("same_addr_final_x9", rf_obs[9], 1);

    // Fill the buffer, then reset: buffer discarded, sweep restarts at 1.
    ex_valid = 1'b1; ex_waddr = 5'd20; ex_wdata = 32'h20;
    lsu_we = 1'b1; lsu_waddr = 5'd21; lsu_wdata = 32'h21;
    exp_q.push_back('{5'd21, 32'h21});
    #4;
    check_port();
    next_cycle();
    chk("full_before_rst", 32'(pend_valid), 1);
    do_reset();
    sweep(0);
    #4;
    chk("pend_after_rst", 32'(pend_valid), 0);
    check_port();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
